// File: rtl/sram_ctrl.sv
// Single-port controller for one asynchronous 32-bit SRAM chip: turns a
// valid/ready word request into timed ce/oe/we strobes and a one-cycle response.
module sram_ctrl #(
    parameter int READ_WAIT  = 2,
    parameter int WRITE_WAIT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    inout  wire  [31:0] ram_data,
    output logic [19:0] ram_addr,
    output logic [3:0]  ram_be_n,
    output logic        ram_ce_n,
    output logic        ram_oe_n,
    output logic        ram_we_n
);
    localparam int MAX_WAIT = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
    localparam int CW       = $clog2(MAX_WAIT) + 1;

    // Handshake: a request transfers on a clk edge where req_valid=1 and
    // req_ready=1; rsp_valid is a single-cycle pulse with no backpressure.
    typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [31:0]   wdata_q, wdata_nxt;
    logic          data_oe, data_oe_nxt;
    logic [19:0]   addr_nxt;
    logic [3:0]    be_n_nxt;
    logic          ce_n_nxt, oe_n_nxt, we_n_nxt;
    logic          rsp_valid_nxt;
    logic [31:0]   rdata_nxt;
    logic          unused_addr;

    assign unused_addr = ^{req_addr[31:22], req_addr[1:0]};
    assign ram_data    = data_oe ? wdata_q : 32'bz;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            wdata_q   <= '0;
            data_oe   <= 1'b0;
            ram_addr  <= '0;
            ram_be_n  <= 4'b1111;
            ram_ce_n  <= 1'b1;
            ram_oe_n  <= 1'b1;
            ram_we_n  <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            wdata_q   <= wdata_nxt;
            data_oe   <= data_oe_nxt;
            ram_addr  <= addr_nxt;
            ram_be_n  <= be_n_nxt;
            ram_ce_n  <= ce_n_nxt;
            ram_oe_n  <= oe_n_nxt;
            ram_we_n  <= we_n_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rdata_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (req_valid) state_nxt = req_we ? WR_SETUP : RD;
            RD:       if (cnt == '0) state_nxt = IDLE;
            WR_SETUP: state_nxt = WR_PULSE;
            WR_PULSE: if (cnt == '0) state_nxt = WR_HOLD;
            WR_HOLD:  state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Next values of the registered pin/response outputs; everything leaving
    // the block toward the chip comes straight from a flop.
    always_comb begin
        req_ready     = (state == IDLE);
        cnt_nxt       = cnt;
        wdata_nxt     = wdata_q;
        data_oe_nxt   = data_oe;
        addr_nxt      = ram_addr;
        be_n_nxt      = ram_be_n;
        ce_n_nxt      = ram_ce_n;
        oe_n_nxt      = ram_oe_n;
        we_n_nxt      = ram_we_n;
        rsp_valid_nxt = 1'b0;
        rdata_nxt     = rsp_rdata;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    addr_nxt  = req_addr[21:2];
                    wdata_nxt = req_wdata;
                    ce_n_nxt  = 1'b0;
                    if (req_we) begin
                        data_oe_nxt = 1'b1;
                        be_n_nxt    = ~req_be;
                        oe_n_nxt    = 1'b1;
                    end else begin
                        oe_n_nxt = 1'b0;
                        be_n_nxt = 4'b0000;
                        cnt_nxt  = CW'(READ_WAIT - 1);
                    end
                end
            end
            RD: begin
                if (cnt == '0) begin
                    rdata_nxt     = ram_data;
                    rsp_valid_nxt = 1'b1;
                    ce_n_nxt      = 1'b1;
                    oe_n_nxt      = 1'b1;
                    be_n_nxt      = 4'b1111;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            WR_SETUP: begin
                cnt_nxt  = CW'(WRITE_WAIT - 1);
                // An all-zero byte mask still runs the full sequence, but no store pulse.
                we_n_nxt = &ram_be_n;
            end
            WR_PULSE: begin
                if (cnt == '0) we_n_nxt = 1'b1;
                else           cnt_nxt  = cnt - CW'(1);
            end
            WR_HOLD: begin
                data_oe_nxt   = 1'b0;
                ce_n_nxt      = 1'b1;
                be_n_nxt      = 4'b1111;
                rsp_valid_nxt = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: table of back-to-back requests against an SRAM model,
// plus reset, abort and READ_WAIT=1 sequences.
module tb_sram_ctrl;
    logic        clk, resetn;
    logic        req_valid, req_ready, req_we;
    logic [3:0]  req_be;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    wire  [31:0] ram_data;
    logic [19:0] ram_addr;
    logic [3:0]  ram_be_n;
    logic        ram_ce_n, ram_oe_n, ram_we_n;

    logic        f_req_valid, f_req_ready, f_req_we;
    logic [3:0]  f_req_be;
    logic [31:0] f_req_addr, f_req_wdata;
    logic        f_rsp_valid;
    logic [31:0] f_rsp_rdata;
    wire  [31:0] f_ram_data;
    logic [19:0] f_ram_addr;
    logic [3:0]  f_ram_be_n;
    logic        f_ram_ce_n, f_ram_oe_n, f_ram_we_n;

    int checks = 0;
    int errors = 0;
    int contention = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mem [0:1023];

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [19:0] exp_addr;
        logic [3:0]  exp_be_n;
        int          exp_lat;
        int          exp_we_low;
        int          exp_oe_low;
        int          exp_drv;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[11];

    sram_ctrl dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ram_data(ram_data), .ram_addr(ram_addr), .ram_be_n(ram_be_n),
        .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
    );

    sram_ctrl #(.READ_WAIT(1), .WRITE_WAIT(2)) dut_fast (
        .clk(clk), .resetn(resetn),
        .req_valid(f_req_valid), .req_ready(f_req_ready), .req_we(f_req_we),
        .req_be(f_req_be), .req_addr(f_req_addr), .req_wdata(f_req_wdata),
        .rsp_valid(f_rsp_valid), .rsp_rdata(f_rsp_rdata),
        .ram_data(f_ram_data), .ram_addr(f_ram_addr), .ram_be_n(f_ram_be_n),
        .ram_ce_n(f_ram_ce_n), .ram_oe_n(f_ram_oe_n), .ram_we_n(f_ram_we_n)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM models: async read while selected and output-enabled, store on we_n low
    assign ram_data   = (!ram_ce_n && !ram_oe_n && ram_we_n) ? mem[ram_addr[9:0]] : 32'bz;
    assign f_ram_data = (!f_ram_ce_n && !f_ram_oe_n) ? 32'hCAFEF00D : 32'bz;

    always @(negedge clk) begin
        if (!ram_ce_n && !ram_we_n) begin
            for (int b = 0; b < 4; b++)
                if (!ram_be_n[b]) mem[ram_addr[9:0]][8*b +: 8] <= ram_data[8*b +: 8];
        end
        if (dut.data_oe && !ram_oe_n) contention++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every response pops the oldest expected rsp_rdata
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 rdata %h expected no response", rsp_rdata);
            end else begin
                check("rsp_rdata", rsp_rdata, exp_q.pop_front());
            end
        end
    end

    // Driver: called at a negedge; returns at the negedge of the response cycle
    task automatic do_req(input int idx, input vec_t v);
        int lat = 0, we_low = 0, oe_low = 0, drv = 0, busy_rdy = 0;
        logic rsp_rdy = 1'b0;
        string tag;
        tag = $sformatf("v%0d", idx);
        exp_q.push_back(v.exp_rdata);
        check({tag, "_ready_at_accept"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = v.we;
        req_be    = v.be;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'($urandom_range(0, 1));
        req_be    = 4'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        check({tag, "_ram_addr"}, 32'(ram_addr), 32'(v.exp_addr));
        check({tag, "_ram_be_n"}, 32'(ram_be_n), 32'(v.exp_be_n));
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            if (k > 1) @(negedge clk);
            if (rsp_valid) begin
                lat = k;
                rsp_rdy = req_ready;
            end else begin
                if (!ram_we_n) we_low++;
                if (!ram_oe_n) oe_low++;
                if (dut.data_oe && ram_data == v.wdata) drv++;
                if (req_ready) busy_rdy++;
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
        check({tag, "_we_low_cycles"}, 32'(we_low), 32'(v.exp_we_low));
        check({tag, "_oe_low_cycles"}, 32'(oe_low), 32'(v.exp_oe_low));
        check({tag, "_data_drive_cycles"}, 32'(drv), 32'(v.exp_drv));
        check({tag, "_busy_ready"}, 32'(busy_rdy), 32'd0);
        check({tag, "_ready_in_rsp"}, 32'(rsp_rdy), 32'd1);
    endtask

    initial begin
        int lat, oe_low, wait_k;
        logic [31:0] f_rdata;

        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[10'h010] = 32'hDEADBEEF;
        mem[10'h041] = 32'hAABBCCDD;

        //           we  be       addr          wdata         addr      be_n    lat we oe drv rdata
        vecs[0]  = '{1'b0, 4'b0000, 32'h00000040, 32'h00000000, 20'h00010, 4'b0000, 3, 0, 2, 0, 32'hDEADBEEF};
        vecs[1]  = '{1'b1, 4'b0011, 32'h00000104, 32'h12345678, 20'h00041, 4'b1100, 5, 2, 0, 4, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 4'b1111, 32'h00000104, 32'h00000000, 20'h00041, 4'b0000, 3, 0, 2, 0, 32'hAABB5678};
        vecs[3]  = '{1'b1, 4'b0000, 32'h00000107, 32'hFFFFFFFF, 20'h00041, 4'b1111, 5, 0, 0, 4, 32'hAABB5678};
        vecs[4]  = '{1'b0, 4'b0000, 32'h00000106, 32'h00000000, 20'h00041, 4'b0000, 3, 0, 2, 0, 32'hAABB5678};
        vecs[5]  = '{1'b1, 4'b1100, 32'h00000200, 32'h11223344, 20'h00080, 4'b0011, 5, 2, 0, 4, 32'hAABB5678};
        vecs[6]  = '{1'b1, 4'b0011, 32'h00000200, 32'h99887766, 20'h00080, 4'b1100, 5, 2, 0, 4, 32'hAABB5678};
        vecs[7]  = '{1'b0, 4'b0000, 32'h00000203, 32'h00000000, 20'h00080, 4'b0000, 3, 0, 2, 0, 32'h11227766};
        vecs[8]  = '{1'b1, 4'b1000, 32'h00400040, 32'h5A000000, 20'h00010, 4'b0111, 5, 2, 0, 4, 32'h11227766};
        vecs[9]  = '{1'b0, 4'b0000, 32'h00000040, 32'h00000000, 20'h00010, 4'b0000, 3, 0, 2, 0, 32'h5AADBEEF};
        vecs[10] = '{1'b0, 4'b0000, 32'hFFC00104, 32'h00000000, 20'h00041, 4'b0000, 3, 0, 2, 0, 32'hAABB5678};

        resetn = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_be = '0; req_addr = '0; req_wdata = '0;
        f_req_valid = 1'b0; f_req_we = 1'b0; f_req_be = '0; f_req_addr = '0; f_req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_ce_oe_we_n", 32'({ram_ce_n, ram_oe_n, ram_we_n}), 32'b111);
        check("rst_be_n", 32'(ram_be_n), 32'hF);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_data_oe", 32'(dut.data_oe), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        @(negedge clk);

        // Each request is issued in the previous one's response cycle
        for (int i = 0; i < 11; i++) do_req(i, vecs[i]);
        @(negedge clk);
        @(negedge clk);

        check("mem_word_010", mem[10'h010], 32'h5AADBEEF);
        check("mem_word_041", mem[10'h041], 32'hAABB5678);
        check("mem_word_080", mem[10'h080], 32'h11227766);

        // Abort a write during its we_n pulse
        req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF;
        req_addr = 32'h00000300; req_wdata = 32'h0BADF00D;
        @(negedge clk);
        req_valid = 1'b0;
        wait_k = 0;
        for (int k = 1; k <= 10 && wait_k == 0; k++) begin
            @(negedge clk);
            if (!ram_we_n) wait_k = k;
        end
        check("abort_reached_pulse", 32'(wait_k != 0), 32'd1);
        resetn = 1'b0;
        @(negedge clk);
        check("abort_we_n", 32'(ram_we_n), 32'd1);
        check("abort_ce_n", 32'(ram_ce_n), 32'd1);
        check("abort_data_oe", 32'(dut.data_oe), 32'd0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("abort_ready_after", 32'(req_ready), 32'd1);
        repeat (3) @(negedge clk);

        // READ_WAIT=1 instance
        f_req_valid = 1'b1; f_req_we = 1'b0; f_req_addr = 32'h00000008;
        @(negedge clk);
        f_req_valid = 1'b0;
        check("fast_ram_addr", 32'(f_ram_addr), 32'd2);
        lat = 0; oe_low = 0; f_rdata = '0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            if (k > 1) @(negedge clk);
            if (f_rsp_valid) begin
                lat = k;
                f_rdata = f_rsp_rdata;
            end else if (!f_ram_oe_n) oe_low++;
        end
        check("fast_latency", 32'(lat), 32'd2);
        check("fast_oe_low_cycles", 32'(oe_low), 32'd1);
        check("fast_rsp_rdata", f_rdata, 32'hCAFEF00D);
        @(negedge clk);

        check("bus_contention_cycles", 32'(contention), 32'd0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
